// File: rtl/computer_system_frame_ram_pkg.sv
// rtl/computer_system_frame_ram_pkg.sv - shared types and parameter helpers for the frame RAM
package computer_system_frame_ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  // Address width for a given word count; never narrower than one bit
  function automatic int addr_w_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One byte-enable bit per byte lane
  function automatic int be_w_of(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/computer_system_frame_ram_core.sv
// rtl/computer_system_frame_ram_core.sv - byte-enabled true-dual-port array, optional output stage (COMPUTER_SYSTEM_FRAME_RAM_OUTREG_EN)
module computer_system_frame_ram_core
  import computer_system_frame_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 307200,
  parameter int ADDR_W = addr_w_of(DEPTH),
  parameter int BE_W   = be_w_of(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic              a_re,
  input  logic [BE_W-1:0]   a_be,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_q,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic              b_re,
  input  logic [BE_W-1:0]   b_be,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_q
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_q1;
  logic [DATA_W-1:0] b_q1;

  // Byte-masked writes; same-word collisions are already resolved by the caller
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (b_we && b_be[i]) mem[b_addr][i*BYTE_W +: BYTE_W] <= b_wdata[i*BYTE_W +: BYTE_W];
      if (a_we && a_be[i]) mem[a_addr][i*BYTE_W +: BYTE_W] <= a_wdata[i*BYTE_W +: BYTE_W];
    end
  end

  // Registered reads see the pre-write contents and hold between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q1 <= '0;
      b_q1 <= '0;
    end else begin
      if (a_re) a_q1 <= mem[a_addr];
      if (b_re) b_q1 <= mem[b_addr];
    end
  end

`ifdef COMPUTER_SYSTEM_FRAME_RAM_OUTREG_EN
  logic              a_re_d;
  logic              b_re_d;
  logic [DATA_W-1:0] a_q2;
  logic [DATA_W-1:0] b_q2;

  // Second stage captures the array output one cycle after each read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_re_d <= 1'b0;
      b_re_d <= 1'b0;
      a_q2   <= '0;
      b_q2   <= '0;
    end else begin
      a_re_d <= a_re;
      b_re_d <= b_re;
      if (a_re_d) a_q2 <= a_q1;
      if (b_re_d) b_q2 <= b_q1;
    end
  end

  assign a_q = a_q2;
  assign b_q = b_q2;
`else
  assign a_q = a_q1;
  assign b_q = b_q1;
`endif

endmodule

// File: rtl/computer_system_frame_ram.sv
// rtl/computer_system_frame_ram.sv - two-slave frame RAM with clear engine (option: COMPUTER_SYSTEM_FRAME_RAM_OUTREG_EN)
module computer_system_frame_ram
  import computer_system_frame_ram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 307200,
  parameter int ADDR_W         = addr_w_of(DEPTH),
  parameter int BE_W           = be_w_of(DATA_W),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_chipselect,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [BE_W-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  output logic              s1_waitrequest,
  input  logic [ADDR_W-1:0] s2_address,
  input  logic              s2_chipselect,
  input  logic              s2_read,
  input  logic              s2_write,
  input  logic [BE_W-1:0]   s2_byteenable,
  input  logic [DATA_W-1:0] s2_writedata,
  output logic [DATA_W-1:0] s2_readdata,
  output logic              s2_readdatavalid,
  output logic              s2_waitrequest,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_value,
  output logic              clear_busy,
  output logic              clear_done
);

  clr_state_t        state;
  clr_state_t        state_next;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_val;
  logic              boot;
  logic              start_clear;
  logic              last_write;

  logic              s1_wr;
  logic              s1_rd;
  logic              s2_wr;
  logic              s2_rd;
  logic [ADDR_W-1:0] b_addr;
  logic              b_we;
  logic [BE_W-1:0]   b_be;
  logic [DATA_W-1:0] b_wdata;
  logic              s1_rv1;
  logic              s2_rv1;

  assign s1_waitrequest = 1'b0;
  assign clear_busy     = (state == CLR_RUN);
  assign s2_waitrequest = clear_busy;

  // Write wins when a master asserts read and write together
  assign s1_wr = s1_chipselect & s1_write & ~s1_waitrequest;
  assign s1_rd = s1_chipselect & s1_read & ~s1_write & ~s1_waitrequest;
  assign s2_wr = s2_chipselect & s2_write & ~s2_waitrequest;
  assign s2_rd = s2_chipselect & s2_read & ~s2_write & ~s2_waitrequest;

  // Port B belongs to the clear engine while busy; an s1 write to the same word suppresses it
  always_comb begin
    b_addr  = s2_address;
    b_be    = s2_byteenable;
    b_wdata = s2_writedata;
    b_we    = s2_wr;
    if (clear_busy) begin
      b_addr  = clr_addr;
      b_be    = '1;
      b_wdata = clr_val;
      b_we    = 1'b1;
    end
    if (s1_wr && (s1_address == b_addr)) b_we = 1'b0;
  end

  // Clear FSM next state: start from idle on request or just after reset, stop after the last word
  always_comb begin
    state_next  = state;
    start_clear = 1'b0;
    last_write  = 1'b0;
    case (state)
      CLR_IDLE: begin
        if (clear_start || (CLEAR_ON_RESET && boot)) begin
          state_next  = CLR_RUN;
          start_clear = 1'b1;
        end
      end
      CLR_RUN: begin
        if (clr_addr == ADDR_W'(DEPTH - 1)) begin
          state_next = CLR_IDLE;
          last_write = 1'b1;
        end
      end
      default: state_next = CLR_IDLE;
    endcase
  end

  // Clear FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLR_IDLE;
    else       state <= state_next;
  end

  // Clear datapath: fill value latch, address counter, done pulse and post-reset marker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      boot       <= 1'b1;
      clr_addr   <= '0;
      clr_val    <= '0;
      clear_done <= 1'b0;
    end else begin
      boot       <= 1'b0;
      clear_done <= last_write;
      if (start_clear) begin
        clr_addr <= '0;
        clr_val  <= clear_value;
      end else if (clear_busy && !last_write) begin
        clr_addr <= clr_addr + ADDR_W'(1);
      end
    end
  end

`ifdef COMPUTER_SYSTEM_FRAME_RAM_OUTREG_EN
  logic s1_rv2;
  logic s2_rv2;

  // Read-valid pipeline matched to the two-stage read path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_rv1 <= 1'b0;
      s2_rv1 <= 1'b0;
      s1_rv2 <= 1'b0;
      s2_rv2 <= 1'b0;
    end else begin
      s1_rv1 <= s1_rd;
      s2_rv1 <= s2_rd;
      s1_rv2 <= s1_rv1;
      s2_rv2 <= s2_rv1;
    end
  end

  assign s1_readdatavalid = s1_rv2;
  assign s2_readdatavalid = s2_rv2;
`else
  // Read-valid follows each accepted read by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_rv1 <= 1'b0;
      s2_rv1 <= 1'b0;
    end else begin
      s1_rv1 <= s1_rd;
      s2_rv1 <= s2_rd;
    end
  end

  assign s1_readdatavalid = s1_rv1;
  assign s2_readdatavalid = s2_rv1;
`endif

  computer_system_frame_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .BE_W   (BE_W)
  ) u_core (
    .clk     (clk),
    .rst     (reset),
    .a_addr  (s1_address),
    .a_we    (s1_wr),
    .a_re    (s1_rd),
    .a_be    (s1_byteenable),
    .a_wdata (s1_writedata),
    .a_q     (s1_readdata),
    .b_addr  (b_addr),
    .b_we    (b_we),
    .b_re    (s2_rd),
    .b_be    (b_be),
    .b_wdata (b_wdata),
    .b_q     (s2_readdata)
  );

endmodule

// File: tb/tb_computer_system_frame_ram.sv
// tb/tb_computer_system_frame_ram.sv - directed self-checking bench for computer_system_frame_ram
module tb_computer_system_frame_ram;

`ifdef COMPUTER_SYSTEM_FRAME_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write;
  logic        s2_chipselect, s2_read, s2_write;
  logic [1:0]  s1_byteenable, s2_byteenable;
  logic [15:0] s1_writedata, s2_writedata;
  logic [15:0] s1_readdata, s2_readdata;
  logic        s1_readdatavalid, s2_readdatavalid;
  logic        s1_waitrequest, s2_waitrequest;
  logic        clear_start;
  logic [15:0] clear_value;
  logic        clear_busy, clear_done;

  int n_assert = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  computer_system_frame_ram #(
    .DATA_W         (16),
    .DEPTH          (16),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .s1_address       (s1_address),
    .s1_chipselect    (s1_chipselect),
    .s1_read          (s1_read),
    .s1_write         (s1_write),
    .s1_byteenable    (s1_byteenable),
    .s1_writedata     (s1_writedata),
    .s1_readdata      (s1_readdata),
    .s1_readdatavalid (s1_readdatavalid),
    .s1_waitrequest   (s1_waitrequest),
    .s2_address       (s2_address),
    .s2_chipselect    (s2_chipselect),
    .s2_read          (s2_read),
    .s2_write         (s2_write),
    .s2_byteenable    (s2_byteenable),
    .s2_writedata     (s2_writedata),
    .s2_readdata      (s2_readdata),
    .s2_readdatavalid (s2_readdatavalid),
    .s2_waitrequest   (s2_waitrequest),
    .clear_start      (clear_start),
    .clear_value      (clear_value),
    .clear_busy       (clear_busy),
    .clear_done       (clear_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (clear_busy === 1'b1) busy_cnt++;
    if (clear_done === 1'b1) done_cnt++;
  endtask

  task automatic wr(input int p, input logic [3:0] a, input logic [1:0] be, input logic [15:0] d);
    @(negedge clk);
    if (p == 1) begin
      s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = a; s1_byteenable = be; s1_writedata = d;
    end else begin
      s2_chipselect = 1'b1; s2_write = 1'b1; s2_address = a; s2_byteenable = be; s2_writedata = d;
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic wait_valid(input int p, input logic [15:0] exp, input string tag);
    int lat;
    lat = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (((p == 1) ? s1_readdatavalid : s2_readdatavalid) === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_data"}, (p == 1) ? s1_readdata : s2_readdata, exp);
    check({tag, "_lat"}, lat, LAT);
  endtask

  task automatic rd(input int p, input logic [3:0] a, input logic [15:0] exp, input string tag);
    int guard;
    @(negedge clk);
    if (p == 1) begin
      s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = a;
    end else begin
      s2_chipselect = 1'b1; s2_read = 1'b1; s2_address = a;
    end
    guard = 0;
    while (p == 2 && s2_waitrequest !== 1'b0 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    idle();
    wait_valid(p, exp, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset = 1'b1;
    idle();
    s1_address = '0; s2_address = '0;
    s1_byteenable = '0; s2_byteenable = '0;
    s1_writedata = '0; s2_writedata = '0;
    clear_start = 1'b0;
    clear_value = 16'hA5A5;

    // reset values while reset is held
    repeat (3) @(negedge clk);
    check("rst_s1_readdata", s1_readdata, 16'h0);
    check("rst_s2_readdata", s2_readdata, 16'h0);
    check("rst_s1_rdv", s1_readdatavalid, 1'b0);
    check("rst_s2_rdv", s2_readdatavalid, 1'b0);
    check("rst_s1_waitreq", s1_waitrequest, 1'b0);
    check("rst_s2_waitreq", s2_waitrequest, 1'b0);
    check("rst_busy", clear_busy, 1'b0);
    check("rst_done", clear_done, 1'b0);

    // auto-clear after release
    reset = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    repeat (30) tick();
    check("autoclr_busy_cycles", busy_cnt, 16);
    check("autoclr_done_pulses", done_cnt, 1);
    for (int i = 0; i < 16; i++) begin
      rd(1, 4'(i), 16'hA5A5, $sformatf("autoclr_s1_%0d", i));
      rd(2, 4'(i), 16'hA5A5, $sformatf("autoclr_s2_%0d", i));
    end

    // byte enables: only the low byte changes
    wr(1, 4'd3, 2'b01, 16'h1234);
    rd(2, 4'd3, 16'hA534, "byteen");

    // mixed-port: s2 read sees old data while s1 writes the same word
    @(negedge clk);
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 4'd5; s1_byteenable = 2'b11; s1_writedata = 16'hBEEF;
    s2_chipselect = 1'b1; s2_read = 1'b1; s2_address = 4'd5;
    @(posedge clk); #1;
    idle();
    wait_valid(2, 16'hA5A5, "mixed_old");
    rd(2, 4'd5, 16'hBEEF, "mixed_new");

    // same-address write collision: s1 wins
    @(negedge clk);
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 4'd7; s1_byteenable = 2'b11; s1_writedata = 16'h1111;
    s2_chipselect = 1'b1; s2_write = 1'b1; s2_address = 4'd7; s2_byteenable = 2'b11; s2_writedata = 16'h2222;
    @(posedge clk); #1;
    idle();
    rd(1, 4'd7, 16'h1111, "collide");

    // simultaneous writes to different words both land
    @(negedge clk);
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 4'd8; s1_byteenable = 2'b11; s1_writedata = 16'h0808;
    s2_chipselect = 1'b1; s2_write = 1'b1; s2_address = 4'd9; s2_byteenable = 2'b11; s2_writedata = 16'h0909;
    @(posedge clk); #1;
    idle();
    rd(2, 4'd8, 16'h0808, "dual_wr_a");
    rd(1, 4'd9, 16'h0909, "dual_wr_b");

    // commanded clear with value 0; value changes after the start are ignored
    @(negedge clk);
    clear_start = 1'b1; clear_value = 16'h0000;
    @(posedge clk); #1;
    clear_start = 1'b0; clear_value = 16'hFFFF;
    busy_cnt = 0; done_cnt = 0;
    repeat (4) tick();
    // clr_addr is 3 here: s1 overwrites it, s2 requests a read, second start pulse
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 4'd3; s1_byteenable = 2'b11; s1_writedata = 16'hCAFE;
    s2_chipselect = 1'b1; s2_read = 1'b1; s2_address = 4'd2;
    clear_start = 1'b1; clear_value = 16'h1234;
    @(posedge clk); #1;
    s1_chipselect = 1'b0; s1_write = 1'b0;
    clear_start = 1'b0;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (s2_waitrequest !== 1'b0 && guard < 40);
    check("midclr_busy_cycles", busy_cnt, 16);
    check("midclr_done_at_release", clear_done, 1'b1);
    check("midclr_done_pulses", done_cnt, 1);
    @(posedge clk); #1;
    idle();
    wait_valid(2, 16'h0000, "midclr_held_read");
    for (int i = 0; i < 16; i++)
      rd(1, 4'(i), (i == 3) ? 16'hCAFE : 16'h0000, $sformatf("midclr_s1_%0d", i));
    rd(2, 4'd3, 16'hCAFE, "midclr_s2_3");
    rd(1, 4'd3, 16'hCAFE, "midclr_s1_3b");

    // reset in the middle of a clear
    @(negedge clk);
    clear_start = 1'b1; clear_value = 16'h5A5A;
    @(posedge clk); #1;
    clear_start = 1'b0;
    repeat (9) @(negedge clk);
    check("rstmid_busy_before", clear_busy, 1'b1);
    reset = 1'b1;
    #1;
    check("rstmid_busy", clear_busy, 1'b0);
    check("rstmid_s2_waitreq", s2_waitrequest, 1'b0);
    check("rstmid_s1_readdata", s1_readdata, 16'h0);
    check("rstmid_s2_readdata", s2_readdata, 16'h0);
    check("rstmid_done", clear_done, 1'b0);
    repeat (2) @(negedge clk);
    check("rstmid_busy_held", clear_busy, 1'b0);
    reset = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    repeat (30) tick();
    check("rstmid_busy_cycles", busy_cnt, 16);
    check("rstmid_done_pulses", done_cnt, 1);
    rd(2, 4'd0, 16'h5A5A, "rstmid_s2_0");
    rd(2, 4'd15, 16'h5A5A, "rstmid_s2_15");
    rd(1, 4'd8, 16'h5A5A, "rstmid_s1_8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/computer_system_frame_ram.md
# computer_system_frame_ram

Parametrised true-dual-port on-chip RAM for the Computer_System pixel/character buffers, the next generation of the fixed 8-bit, 307200-word two-slave RAM. It exposes two Avalon-MM slaves, s1 and s2, on one clock. Both slaves support byte enables and read-valid signalling. A built-in clear engine fills the whole array with a programmable value, either after reset or on command. It sits between the HPS/bridge side (s1) and a video DMA or pixel writer (s2).

## Interface
- DATA_W, 8: word width in bits; must be a multiple of 8.
- DEPTH, 307200: number of words (640×480).
- ADDR_W, $clog2(DEPTH): address width.
- BE_W, DATA_W/8: byte-enable width.
- CLEAR_ON_RESET, 1: start a clear automatically on the first cycle after reset deasserts.
- clk in 1: single clock for both slaves and the clear engine.
- reset in 1: asynchronous, active-high.
- s1_address in ADDR_W: port 1 word address.
- s1_chipselect, s1_read, s1_write in 1: port 1 access strobes.
- s1_byteenable in BE_W; s1_writedata in DATA_W: port 1 write controls and data.
- s1_readdata out DATA_W; s1_readdatavalid out 1; s1_waitrequest out 1 (tied 0).
- s2_* : same set as s1. s2_waitrequest is driven by the clear engine.
- clear_start in 1: one-cycle pulse that requests a clear.
- clear_value in DATA_W: fill word; sampled on the cycle the clear starts.
- clear_busy out 1: clear in progress.
- clear_done out 1: one-cycle pulse after the last clear write.

## Operation
- Access acceptance:
  - A port accepts an access when chipselect & (read | write) & ~waitrequest.
  - read and write asserted together is illegal; write takes priority.
- Writes: only bytes with byteenable=1 are updated.
- Reads:
  - readdatavalid is high exactly once per accepted read, in order.
  - readdata holds its last value otherwise.
- Mixed-port read/write to the same address in the same cycle: the read returns the OLD data.
- Same-address write collision: s1 wins and the s2 write is dropped (no waitrequest). The same rule applies when the clear engine collides with s1: the s1 data is kept.
- Clear FSM states:
  - IDLE: clear_busy=0, s2_waitrequest=0.
  - IDLE -> CLEAR on clear_start, or on the first post-reset cycle when CLEAR_ON_RESET=1. Entering CLEAR latches clear_value and sets clr_addr=0.
  - CLEAR: each cycle writes the latched value to clr_addr with all bytes enabled, via the port B side, then increments clr_addr. clear_busy=1 and s2_waitrequest=1, so Avalon s2 masters hold their request.
  - CLEAR -> IDLE after the write to DEPTH-1; clear_done pulses on the following cycle. clr_addr does not wrap.
- clear_start while in CLEAR is ignored; the clear does not restart.
- s1 runs at full rate during a clear.
- Reset mid-clear: the FSM goes to IDLE immediately and RAM contents are undefined. The clear restarts only if CLEAR_ON_RESET=1.
- Memory contents are not initialised by reset.

## Timing
- Read latency is 1 cycle: readdatavalid/readdata are registered on the clk edge after acceptance. With COMPUTER_SYSTEM_FRAME_RAM_OUTREG_EN the latency is 2 cycles.
- Write latency: data is visible to a read accepted on the next cycle.
- Clear duration is exactly DEPTH cycles in CLEAR, plus 1 cycle for the clear_done pulse.
- Reset values:
  - s1_readdata=0, s2_readdata=0.
  - s1_readdatavalid=0, s2_readdatavalid=0.
  - s1_waitrequest=0, clear_done=0.
  - clear_busy=0 and s2_waitrequest=0 while reset is held, even with CLEAR_ON_RESET=1 (auto-clear begins the cycle after release).
- Throughput: one access per port per cycle.

## Configuration
- COMPUTER_SYSTEM_FRAME_RAM_OUTREG_EN:
  - Defined: adds an output register stage to both ports, giving read latency 2 with readdatavalid delayed to match. Needed for 307200-word depth above 100 MHz.
  - Undefined: read latency 1, no extra stage.
- The collision and mixed-port rules are identical in both builds.

## Structure
- Package computer_system_frame_ram_pkg holds:
  - the clear FSM enum (CLR_IDLE, CLR_RUN);
  - localparam helpers for ADDR_W/BE_W derivation.
- Sub-module computer_system_frame_ram_core: the inferred byte-enabled true-dual-port array. It has old-data mixed-port behaviour and the optional output register. The top level holds the Avalon handshakes, collision arbitration, the clear FSM and the readdatavalid pipelines.

## Test plan
All scenarios use DATA_W=16, DEPTH=16, CLEAR_ON_RESET=1.
- Auto-clear:
  - Stimulus: release reset with clear_value=16'hA5A5.
  - Required response: clear_busy is high for 16 cycles, clear_done pulses once, then reads of addresses 0..15 on both ports all return A5A5.
- Byte enables:
  - Stimulus: s1 writes 16'h1234 to address 3 with byteenable=2'b01, then s2 reads address 3.
  - Required response: readdata=16'hA534, with readdatavalid exactly 1 cycle after acceptance (2 with OUTREG_EN).
- Mixed-port read/write:
  - Stimulus: in the same cycle, s1 writes 16'hBEEF to address 5 while s2 reads address 5.
  - Required response: s2 gets the old value A5A5; a read on the next cycle returns BEEF.
- Same-address write collision:
  - Stimulus: s1 writes 16'h1111 and s2 writes 16'h2222 to address 7 in the same cycle.
  - Required response: address 7 reads back 16'h1111.
- clear_start mid-clear:
  - Stimulus: clear_start with clear_value=0; during the clear, s2 issues a read and s1 writes 16'hCAFE to the current clr_addr.
  - Required response: s2_waitrequest holds the read until clear_done; that location reads CAFE; every other location reads 0; a second clear_start pulse mid-clear has no effect.
- Reset mid-clear:
  - Stimulus: assert reset at clr_addr=8.
  - Required response: all outputs take their reset values asynchronously, and a new 16-cycle clear starts after release.
